// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state encoding for the SPI frame sequencer
package spi_pkg;
  localparam int SPI_W_DEF = 8;
  localparam logic [7:0] FILL_WORD_DEF = 8'hFF;
  typedef enum logic [3:0] {
    RST0, RST1, ST_LOAD, TX_LOAD, BUSY_WAIT, RRDY_LOW, RX_WAIT, RX_REQ, RX_CAP, FRAME_OUT
  } state_t;
endpackage

// File: rtl/spi_frame_txbuf.sv
// spi_frame_txbuf: shadow/active tx frame buffers with valid/ready intake and per-word select
module spi_frame_txbuf #(
  parameter int SPI_W = 8,
  parameter int FRAME_WORDS = 4,
  parameter int WCW = 2,
  parameter logic [SPI_W-1:0] FILL_WORD = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [WCW-1:0]               word_cnt,
  input  logic [SPI_W*FRAME_WORDS-1:0] tx_frame,
  input  logic                         tx_frame_valid,
  output logic                         tx_frame_ready,
  output logic                         tx_underrun,
  output logic [SPI_W-1:0]             word
);
  localparam int FW = SPI_W * FRAME_WORDS;
  logic [FW-1:0] shadow, active, src;
  logic full;
  assign tx_frame_ready = en && !full;
  // at frame start the word-0 select sees the frame being moved in, not the stale active one
  assign src = start ? (full ? shadow : {FRAME_WORDS{FILL_WORD}}) : active;
  assign word = src[(FRAME_WORDS-1-int'(word_cnt))*SPI_W +: SPI_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shadow <= '0;
      active <= '0;
      full <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= start && !full;
      if (start) begin
        active <= src;
        full <= 1'b0;
      end
      if (tx_frame_valid && tx_frame_ready) begin
        shadow <= tx_frame;
        full <= 1'b1;
      end
    end
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI slave frame sequencer with rx frame assembly, tx buffering and inactivity timeout
module spi_frame_ctrl import spi_pkg::*; #(
  parameter int SPI_W = SPI_W_DEF,
  parameter int FRAME_WORDS = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter logic [SPI_W-1:0] FILL_WORD = SPI_W'(FILL_WORD_DEF)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         echo_mode,
  output logic [SPI_W*FRAME_WORDS-1:0] rx_frame,
  output logic                         rx_frame_valid,
  input  logic                         rx_frame_ready,
  input  logic [SPI_W*FRAME_WORDS-1:0] tx_frame,
  input  logic                         tx_frame_valid,
  output logic                         tx_frame_ready,
  output logic                         tx_underrun,
  output logic                         frame_err,
  output logic                         spi_rst,
  output logic                         spi_rx_req,
  output logic                         spi_st_load_en,
  output logic                         spi_st_load_trdy,
  output logic                         spi_st_load_rrdy,
  output logic                         spi_st_load_roe,
  output logic                         spi_tx_load_en,
  output logic [SPI_W-1:0]             spi_tx_data,
  input  logic                         spi_trdy,
  input  logic                         spi_rrdy,
  input  logic                         spi_busy,
  input  logic [SPI_W-1:0]             spi_rx_data
);
  localparam int WCW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC);
  localparam logic [WCW-1:0] LAST = WCW'(FRAME_WORDS - 1);
  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [WCW-1:0] word_cnt, word_cnt_n;
  logic [TCW-1:0] tmo, tmo_n;
  logic [SPI_W-1:0] last_rx, buf_word;
  logic echo_q, echo_n, tx_load, frame_start, timing, abort;
  assign tx_load = state == TX_LOAD;
  assign frame_start = tx_load && word_cnt == '0;
  assign echo_n = frame_start ? echo_mode : echo_q;
  assign spi_st_load_trdy = 1'b0;
  assign spi_st_load_rrdy = 1'b0;
  assign spi_st_load_roe = 1'b0;
  spi_frame_txbuf #(.SPI_W(SPI_W), .FRAME_WORDS(FRAME_WORDS), .WCW(WCW), .FILL_WORD(FILL_WORD)) u_txbuf (
    .clk(clk),
    .rst(rst),
    .en(state != RST0 && state != RST1),
    .start(frame_start && !echo_mode),
    .word_cnt(word_cnt),
    .tx_frame(tx_frame),
    .tx_frame_valid(tx_frame_valid),
    .tx_frame_ready(tx_frame_ready),
    .tx_underrun(tx_underrun),
    .word(buf_word)
  );
  always_comb begin
    state_n = state;
    word_cnt_n = word_cnt;
    tmo_n = tmo;
    abort = 1'b0;
    // only gaps inside a frame are timed; waiting for word 0 may last forever
    timing = (state == BUSY_WAIT || state == RRDY_LOW || state == RX_WAIT) && word_cnt != '0;
    if (timing && tmo == TMAX) begin
      abort = 1'b1;
      state_n = RST1;
      word_cnt_n = '0;
    end else begin
      tmo_n = timing ? tmo + 1'b1 : tmo;
      case (state)
        RST0:      state_n = RST1;
        RST1:      state_n = ST_LOAD;
        ST_LOAD:   state_n = TX_LOAD;
        TX_LOAD:   state_n = BUSY_WAIT;
        BUSY_WAIT: state_n = spi_busy ? RRDY_LOW : BUSY_WAIT;
        RRDY_LOW:  state_n = spi_rrdy ? RRDY_LOW : RX_WAIT;
        RX_WAIT:   state_n = spi_rrdy ? RX_REQ : RX_WAIT;
        RX_REQ:    state_n = spi_busy ? RX_REQ : RX_CAP;
        RX_CAP: begin
          state_n = word_cnt == LAST ? FRAME_OUT : TX_LOAD;
          word_cnt_n = word_cnt == LAST ? word_cnt : word_cnt + 1'b1;
        end
        FRAME_OUT: begin
          state_n = rx_frame_valid && rx_frame_ready ? TX_LOAD : FRAME_OUT;
          word_cnt_n = rx_frame_valid && rx_frame_ready ? '0 : word_cnt;
        end
        default:   state_n = RST0;
      endcase
    end
    if (state_n == TX_LOAD && state != TX_LOAD) tmo_n = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RST0;
      word_cnt <= '0;
      tmo <= '0;
      echo_q <= 1'b0;
      last_rx <= '0;
      rx_frame <= '0;
      rx_frame_valid <= 1'b0;
      frame_err <= 1'b0;
      spi_rst <= 1'b0;
      spi_rx_req <= 1'b0;
      spi_st_load_en <= 1'b0;
      spi_tx_load_en <= 1'b0;
      spi_tx_data <= '0;
    end else begin
      state <= state_n;
      word_cnt <= word_cnt_n;
      tmo <= tmo_n;
      echo_q <= echo_n;
      spi_rst <= state != RST0;
      spi_st_load_en <= state == ST_LOAD;
      spi_tx_load_en <= tx_load;
      spi_rx_req <= state == RX_REQ && !spi_busy;
      frame_err <= abort;
      rx_frame_valid <= state == FRAME_OUT && !(rx_frame_valid && rx_frame_ready);
      if (tx_load) spi_tx_data <= echo_n ? last_rx : buf_word;
      if (state == RX_CAP) begin
        rx_frame[(FRAME_WORDS-1-int'(word_cnt))*SPI_W +: SPI_W] <= spi_rx_data;
        last_rx <= spi_rx_data;
      end
    end
endmodule
